// File: rtl/exception_ctrl_pkg.sv
// exc_pkg: shared types and constants for the exception sequencer.
//   state_t          - sequencer states (3-bit enum)
//   CAUSE_*          - cause codes written to CP0 Cause
//   DEFAULT_VECTOR   - default handler entry PC
package exc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SAVE    = 3'd1,
        ST_VECTOR  = 3'd2,
        ST_HANDLER = 3'd3,
        ST_RETURN  = 3'd4
    } state_t;

    localparam logic [4:0]  CAUSE_IRQ_BASE = 5'h10;
    localparam logic [4:0]  CAUSE_SYSCALL  = 5'h08;
    localparam logic [4:0]  CAUSE_RI       = 5'h0A;

    localparam logic [31:0] DEFAULT_VECTOR = 32'h0000_0004;

endpackage

// File: rtl/exception_ctrl_irq_pending.sv
// irq_pending: rising-edge detection of the interrupt lines, sticky pending
// register, masking and lowest-index priority encoding.
//   clk, rst      - clock, synchronous active-high reset
//   irq_i         - raw interrupt lines
//   irq_mask_i    - per-line enable (1 = enabled)
//   ack_i         - one-hot acknowledge; clears the matching pending bit
//   req_valid_o   - some enabled line is pending
//   req_idx_o     - lowest enabled pending index
module irq_pending #(
    parameter int unsigned N_IRQ = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq_i,
    input  logic [N_IRQ-1:0] irq_mask_i,
    input  logic [N_IRQ-1:0] ack_i,
    output logic             req_valid_o,
    output logic [IDX_W-1:0] req_idx_o
);

    logic [N_IRQ-1:0] irq_prev;
    logic [N_IRQ-1:0] pending;
    logic [N_IRQ-1:0] enabled;

    // Set has priority over acknowledge on the same bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_prev <= '0;
            pending  <= '0;
        end else begin
            irq_prev <= irq_i;
            pending  <= (pending & ~ack_i) | (irq_i & ~irq_prev);
        end
    end

    // Scan from the top down so the lowest enabled index is the last write.
    always_comb begin
        enabled     = pending & irq_mask_i;
        req_valid_o = 1'b0;
        req_idx_o   = '0;
        for (int unsigned i = N_IRQ; i > 0; i--) begin
            if (enabled[i-1]) begin
                req_valid_o = 1'b1;
                req_idx_o   = IDX_W'(i - 1);
            end
        end
    end

endmodule

// File: rtl/exception_ctrl.sv
// exception_ctrl: sequences exception/interrupt entry and ERET return.
//   Entry:  IDLE -> SAVE (EPC/Cause strobes) -> VECTOR (redirect to handler,
//           irq ack) -> HANDLER (waits for ERET, no nesting)
//   Return: HANDLER -> RETURN (redirect to EPC) -> IDLE
//   Inputs:  irq_i/irq_mask_i/ie_i interrupt request and enables,
//            exc_valid_i/exc_code_i synchronous exception, pc_i resume PC,
//            eret_i return request, epc_i EPC read back from CP0
//   Outputs: write_epc_o/write_cause_o/cause_o/epc_pc_o CP0 writes,
//            flush_o/redirect_o/redirect_pc_o front-end control,
//            irq_ack_o one-hot ack, in_handler_o, err_o sticky protocol error
// All outputs are registered and change together with the state register.
module exception_ctrl
    import exc_pkg::*;
#(
    parameter int unsigned N_IRQ       = 4,
    parameter logic [31:0] VECTOR_ADDR = DEFAULT_VECTOR
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq_i,
    input  logic [N_IRQ-1:0] irq_mask_i,
    input  logic             ie_i,
    input  logic             exc_valid_i,
    input  logic [4:0]       exc_code_i,
    input  logic [31:0]      pc_i,
    input  logic             eret_i,
    input  logic [31:0]      epc_i,
    output logic             write_epc_o,
    output logic             write_cause_o,
    output logic [4:0]       cause_o,
    output logic [31:0]      epc_pc_o,
    output logic             flush_o,
    output logic             redirect_o,
    output logic [31:0]      redirect_pc_o,
    output logic [N_IRQ-1:0] irq_ack_o,
    output logic             in_handler_o,
    output logic             err_o
);

    localparam int unsigned IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    state_t           state, state_n;
    logic [4:0]       cause_q, cause_n;
    logic [31:0]      epc_q, epc_n;
    logic             is_irq_q, is_irq_n;
    logic [IDX_W-1:0] idx_q, idx_n;
    logic             err_n;

    logic             req_valid;
    logic [IDX_W-1:0] req_idx;

    logic             write_epc_n, write_cause_n, flush_n, redirect_n, in_handler_n;
    logic [4:0]       cause_out_n;
    logic [31:0]      epc_pc_n, redirect_pc_n;
    logic [N_IRQ-1:0] irq_ack_n;

    irq_pending #(
        .N_IRQ (N_IRQ),
        .IDX_W (IDX_W)
    ) u_irq_pending (
        .clk         (clk),
        .rst         (rst),
        .irq_i       (irq_i),
        .irq_mask_i  (irq_mask_i),
        .ack_i       (irq_ack_o),
        .req_valid_o (req_valid),
        .req_idx_o   (req_idx)
    );

    // Next state and latched entry context.
    always_comb begin
        state_n  = state;
        cause_n  = cause_q;
        epc_n    = epc_q;
        is_irq_n = is_irq_q;
        idx_n    = idx_q;
        err_n    = err_o;
        case (state)
            ST_IDLE: begin
                if (exc_valid_i) begin
                    state_n  = ST_SAVE;
                    cause_n  = exc_code_i;
                    epc_n    = pc_i;
                    is_irq_n = 1'b0;
                    idx_n    = '0;
                end else if (ie_i && req_valid) begin
                    state_n  = ST_SAVE;
                    cause_n  = CAUSE_IRQ_BASE + 5'(req_idx);
                    epc_n    = pc_i;
                    is_irq_n = 1'b1;
                    idx_n    = req_idx;
                end
                if (eret_i) begin
                    err_n = 1'b1;
                end
            end
            ST_SAVE:   state_n = ST_VECTOR;
            ST_VECTOR: state_n = ST_HANDLER;
            ST_HANDLER: begin
                if (eret_i) begin
                    state_n = ST_RETURN;
                end
                if (exc_valid_i) begin
                    err_n = 1'b1;
                end
            end
            ST_RETURN: state_n = ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase
    end

    // Output values for the state being entered, so they register alongside it.
    // SAVE uses the context being latched this cycle (cause_n/epc_n); RETURN
    // captures epc_i in the cycle ERET is accepted.
    always_comb begin
        write_epc_n   = 1'b0;
        write_cause_n = 1'b0;
        cause_out_n   = '0;
        epc_pc_n      = '0;
        flush_n       = 1'b0;
        redirect_n    = 1'b0;
        redirect_pc_n = '0;
        irq_ack_n     = '0;
        in_handler_n  = 1'b0;
        case (state_n)
            ST_SAVE: begin
                write_epc_n   = 1'b1;
                write_cause_n = 1'b1;
                flush_n       = 1'b1;
                cause_out_n   = cause_n;
                epc_pc_n      = epc_n;
            end
            ST_VECTOR: begin
                redirect_n    = 1'b1;
                redirect_pc_n = VECTOR_ADDR;
                flush_n       = 1'b1;
                if (is_irq_q) begin
                    irq_ack_n[idx_q] = 1'b1;
                end
            end
            ST_HANDLER: in_handler_n = 1'b1;
            ST_RETURN: begin
                redirect_n    = 1'b1;
                redirect_pc_n = epc_i;
                flush_n       = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            cause_q       <= '0;
            epc_q         <= '0;
            is_irq_q      <= 1'b0;
            idx_q         <= '0;
            err_o         <= 1'b0;
            write_epc_o   <= 1'b0;
            write_cause_o <= 1'b0;
            cause_o       <= '0;
            epc_pc_o      <= '0;
            flush_o       <= 1'b0;
            redirect_o    <= 1'b0;
            redirect_pc_o <= '0;
            irq_ack_o     <= '0;
            in_handler_o  <= 1'b0;
        end else begin
            state         <= state_n;
            cause_q       <= cause_n;
            epc_q         <= epc_n;
            is_irq_q      <= is_irq_n;
            idx_q         <= idx_n;
            err_o         <= err_n;
            write_epc_o   <= write_epc_n;
            write_cause_o <= write_cause_n;
            cause_o       <= cause_out_n;
            epc_pc_o      <= epc_pc_n;
            flush_o       <= flush_n;
            redirect_o    <= redirect_n;
            redirect_pc_o <= redirect_pc_n;
            irq_ack_o     <= irq_ack_n;
            in_handler_o  <= in_handler_n;
        end
    end

endmodule

// File: tb/tb_exception_ctrl.sv
// Bench for exception_ctrl: a directed vector table, hand-written multi-cycle
// sequences, then random stimulus checked against a behavioural model.
module tb_exception_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  irq_i, irq_mask_i;
    logic        ie_i, exc_valid_i, eret_i;
    logic [4:0]  exc_code_i;
    logic [31:0] pc_i, epc_i;
    logic        write_epc_o, write_cause_o, flush_o, redirect_o, in_handler_o, err_o;
    logic [4:0]  cause_o;
    logic [31:0] epc_pc_o, redirect_pc_o;
    logic [3:0]  irq_ack_o;

    always #5 clk = ~clk;

    exception_ctrl #(
        .N_IRQ       (4),
        .VECTOR_ADDR (32'h0000_0004)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .irq_i         (irq_i),
        .irq_mask_i    (irq_mask_i),
        .ie_i          (ie_i),
        .exc_valid_i   (exc_valid_i),
        .exc_code_i    (exc_code_i),
        .pc_i          (pc_i),
        .eret_i        (eret_i),
        .epc_i         (epc_i),
        .write_epc_o   (write_epc_o),
        .write_cause_o (write_cause_o),
        .cause_o       (cause_o),
        .epc_pc_o      (epc_pc_o),
        .flush_o       (flush_o),
        .redirect_o    (redirect_o),
        .redirect_pc_o (redirect_pc_o),
        .irq_ack_o     (irq_ack_o),
        .in_handler_o  (in_handler_o),
        .err_o         (err_o)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 writing EPC/Cause, 2 jumping to vector,
    //        3 inside handler, 4 returning to EPC
    int          m_phase = 0;
    int          m_line  = -1;
    bit [3:0]    m_pend  = '0;
    bit [3:0]    m_prev  = '0;
    bit          m_err   = 1'b0;
    bit [4:0]    m_cause = '0;
    bit [31:0]   m_epc   = '0;
    bit [31:0]   m_ret   = '0;
    bit          e_we, e_wc, e_flush, e_redir, e_inh, e_err;
    bit [4:0]    e_cause;
    bit [31:0]   e_epcpc, e_rpc;
    bit [3:0]    e_ack;

    task automatic model_edge();
        bit [3:0] rise;
        int       nxt;
        if (rst) begin
            m_phase = 0; m_line = -1; m_pend = '0; m_prev = '0; m_err = 1'b0;
        end else begin
            rise = irq_i & ~m_prev;
            nxt  = m_phase;
            case (m_phase)
                0: begin
                    if (exc_valid_i) begin
                        m_cause = exc_code_i; m_epc = pc_i; m_line = -1; nxt = 1;
                    end else if (ie_i) begin
                        for (int n = 0; n < 4; n++) begin
                            if (m_pend[n] && irq_mask_i[n]) begin
                                m_cause = 5'd16 + 5'(n); m_epc = pc_i; m_line = n; nxt = 1;
                                break;
                            end
                        end
                    end
                    if (eret_i) m_err = 1'b1;
                end
                1: nxt = 2;
                2: nxt = 3;
                3: begin
                    if (exc_valid_i) m_err = 1'b1;
                    if (eret_i) begin nxt = 4; m_ret = epc_i; end
                end
                default: nxt = 0;
            endcase
            m_pend  = (m_pend & ~e_ack) | rise;
            m_prev  = irq_i;
            m_phase = nxt;
        end
        e_we = 0; e_wc = 0; e_flush = 0; e_redir = 0; e_inh = 0;
        e_cause = '0; e_epcpc = '0; e_rpc = '0; e_ack = '0;
        case (m_phase)
            1: begin e_we = 1; e_wc = 1; e_flush = 1; e_cause = m_cause; e_epcpc = m_epc; end
            2: begin
                e_redir = 1; e_flush = 1; e_rpc = 32'h4;
                if (m_line >= 0) e_ack = 4'b0001 << m_line;
            end
            3: e_inh = 1;
            4: begin e_redir = 1; e_flush = 1; e_rpc = m_ret; end
            default: ;
        endcase
        e_err = m_err;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".write_epc"},   32'(write_epc_o),   32'(e_we));
        chk({tag, ".write_cause"}, 32'(write_cause_o), 32'(e_wc));
        chk({tag, ".cause"},       32'(cause_o),       32'(e_cause));
        chk({tag, ".epc_pc"},      epc_pc_o,           e_epcpc);
        chk({tag, ".flush"},       32'(flush_o),       32'(e_flush));
        chk({tag, ".redirect"},    32'(redirect_o),    32'(e_redir));
        chk({tag, ".redirect_pc"}, redirect_pc_o,      e_rpc);
        chk({tag, ".irq_ack"},     32'(irq_ack_o),     32'(e_ack));
        chk({tag, ".in_handler"},  32'(in_handler_o),  32'(e_inh));
        chk({tag, ".err"},         32'(err_o),         32'(e_err));
    endtask

    // Inputs are driven 1 time unit after the edge and sampled there too.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic quiet();
        rst = 0; irq_i = '0; exc_valid_i = 0; eret_i = 0; exc_code_i = '0; pc_i = '0;
    endtask

    task automatic do_reset();
        quiet(); rst = 1; step(); rst = 0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit rst; bit [3:0] irq; bit [3:0] mask; bit ie; bit exc; bit [4:0] code;
        bit [31:0] pc; bit eret; bit [31:0] epc;
        bit we; bit wc; bit [4:0] cause; bit [31:0] epcpc; bit flush; bit redir;
        bit [31:0] rpc; bit [3:0] ack; bit inh; bit err;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        //            rst irq  mask  ie exc code   pc      eret epc         we wc cause  epcpc   fl rd rpc          ack inh err
        tbl[0] = '{1, 0, 0,     0, 0, 0,     0,      0, 0,           0, 0, 0,     0,      0, 0, 0,           0, 0, 0};
        tbl[1] = '{0, 0, 4'hF,  0, 1, 5'h08, 32'h40, 0, 0,           1, 1, 5'h08, 32'h40, 1, 0, 0,           0, 0, 0};
        tbl[2] = '{0, 0, 4'hF,  0, 0, 0,     0,      0, 0,           0, 0, 0,     0,      1, 1, 32'h4,       0, 0, 0};
        tbl[3] = '{0, 0, 4'hF,  0, 0, 0,     0,      0, 0,           0, 0, 0,     0,      0, 0, 0,           0, 1, 0};
        tbl[4] = '{0, 0, 4'hF,  0, 0, 0,     0,      0, 0,           0, 0, 0,     0,      0, 0, 0,           0, 1, 0};
        tbl[5] = '{0, 0, 4'hF,  0, 0, 0,     0,      1, 32'h1234,    0, 0, 0,     0,      1, 1, 32'h1234,    0, 0, 0};
        tbl[6] = '{0, 0, 4'hF,  0, 0, 0,     0,      0, 32'h1234,    0, 0, 0,     0,      0, 0, 0,           0, 0, 0};
        tbl[7] = '{0, 0, 4'hF,  0, 0, 0,     0,      1, 32'h1234,    0, 0, 0,     0,      0, 0, 0,           0, 0, 1};
        tbl[8] = '{0, 0, 4'hF,  0, 0, 0,     0,      0, 0,           0, 0, 0,     0,      0, 0, 0,           0, 0, 1};
        tbl[9] = '{1, 0, 4'hF,  0, 0, 0,     0,      0, 0,           0, 0, 0,     0,      0, 0, 0,           0, 0, 0};

        quiet(); irq_mask_i = '0; ie_i = 0; epc_i = '0;
        for (int i = 0; i < 10; i++) begin
            rst = tbl[i].rst; irq_i = tbl[i].irq; irq_mask_i = tbl[i].mask; ie_i = tbl[i].ie;
            exc_valid_i = tbl[i].exc; exc_code_i = tbl[i].code; pc_i = tbl[i].pc;
            eret_i = tbl[i].eret; epc_i = tbl[i].epc;
            step();
            chk($sformatf("tbl%0d.write_epc", i),   32'(write_epc_o),   32'(tbl[i].we));
            chk($sformatf("tbl%0d.write_cause", i), 32'(write_cause_o), 32'(tbl[i].wc));
            chk($sformatf("tbl%0d.cause", i),       32'(cause_o),       32'(tbl[i].cause));
            chk($sformatf("tbl%0d.epc_pc", i),      epc_pc_o,           tbl[i].epcpc);
            chk($sformatf("tbl%0d.flush", i),       32'(flush_o),       32'(tbl[i].flush));
            chk($sformatf("tbl%0d.redirect", i),    32'(redirect_o),    32'(tbl[i].redir));
            chk($sformatf("tbl%0d.redirect_pc", i), redirect_pc_o,      tbl[i].rpc);
            chk($sformatf("tbl%0d.irq_ack", i),     32'(irq_ack_o),     32'(tbl[i].ack));
            chk($sformatf("tbl%0d.in_handler", i),  32'(in_handler_o),  32'(tbl[i].inh));
            chk($sformatf("tbl%0d.err", i),         32'(err_o),         32'(tbl[i].err));
        end

        // IRQ priority: lines 1 and 2 together, line 1 first, line 2 after ERET.
        do_reset(); irq_mask_i = 4'hF; ie_i = 1;
        irq_i = 4'b0110; step(); irq_i = '0;
        step(); chk("prio.save_cause", 32'(cause_o), 32'h11);
        chk("prio.save_we", 32'(write_epc_o), 32'h1);
        step(); chk("prio.vec_ack", 32'(irq_ack_o), 32'h2);
        chk("prio.vec_redir", 32'(redirect_o), 32'h1);
        step(); chk("prio.in_handler", 32'(in_handler_o), 32'h1);
        eret_i = 1; epc_i = 32'h200; step(); eret_i = 0;
        chk("prio.ret_pc", redirect_pc_o, 32'h200);
        step(); chk("prio.idle_redir", 32'(redirect_o), 32'h0);
        step(); chk("prio.second_cause", 32'(cause_o), 32'h12);
        step(); chk("prio.second_ack", 32'(irq_ack_o), 32'h4);
        step(); eret_i = 1; step(); eret_i = 0; step();

        // Masking: pending retained while masked, taken once unmasked.
        do_reset(); irq_mask_i = 4'b0111; ie_i = 1;
        irq_i = 4'b1000; step(); irq_i = '0;
        for (int k = 0; k < 3; k++) begin
            step(); chk($sformatf("mask.no_entry%0d", k), 32'(write_cause_o), 32'h0);
        end
        irq_mask_i = 4'hF; step();
        chk("mask.entry_cause", 32'(cause_o), 32'h13);
        step(); chk("mask.ack", 32'(irq_ack_o), 32'h8);
        step(); eret_i = 1; step(); eret_i = 0; step();

        // Exception beats a pending IRQ in the same cycle; IRQ follows RETURN.
        do_reset(); irq_mask_i = 4'hF; ie_i = 1;
        irq_i = 4'b0001; step(); irq_i = '0;
        exc_valid_i = 1; exc_code_i = 5'h0A; pc_i = 32'h100; step(); exc_valid_i = 0;
        chk("coll.cause", 32'(cause_o), 32'h0A);
        chk("coll.epc_pc", epc_pc_o, 32'h100);
        step(); chk("coll.ack_zero", 32'(irq_ack_o), 32'h0);
        step(); eret_i = 1; epc_i = 32'h100; step(); eret_i = 0;
        chk("coll.ret_pc", redirect_pc_o, 32'h100);
        step(); step(); chk("coll.irq_cause", 32'(cause_o), 32'h10);
        step(); chk("coll.irq_ack", 32'(irq_ack_o), 32'h1);
        step(); eret_i = 1; step(); eret_i = 0; step();

        // Reset during SAVE: outputs clear, pending IRQ is dropped.
        do_reset(); irq_mask_i = 4'hF; ie_i = 0;
        irq_i = 4'b0001; step(); irq_i = '0; step();
        exc_valid_i = 1; exc_code_i = 5'h08; pc_i = 32'h40; step(); exc_valid_i = 0;
        chk("rst.in_save", 32'(write_epc_o), 32'h1);
        rst = 1; step(); rst = 0;
        chk("rst.outs", {write_epc_o, write_cause_o, flush_o, redirect_o, in_handler_o,
                         err_o, cause_o, irq_ack_o}, 32'h0);
        chk("rst.epc_pc", epc_pc_o, 32'h0);
        chk("rst.redirect_pc", redirect_pc_o, 32'h0);
        ie_i = 1;
        for (int k = 0; k < 4; k++) begin
            step(); chk($sformatf("rst.no_irq%0d", k), 32'({write_cause_o, redirect_o}), 32'h0);
        end
        exc_valid_i = 1; exc_code_i = 5'h08; pc_i = 32'h44; step(); exc_valid_i = 0;
        chk("rst.idle_entry", 32'(write_cause_o), 32'h1);
        step(); step(); eret_i = 1; step(); eret_i = 0; step();

        // Random stimulus against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst         = ($urandom_range(0, 199) == 0);
            irq_i       = 4'($urandom);
            irq_mask_i  = 4'($urandom);
            ie_i        = ($urandom_range(0, 3) != 0);
            exc_valid_i = ($urandom_range(0, 7) == 0);
            exc_code_i  = 5'($urandom_range(0, 15));
            pc_i        = $urandom;
            eret_i      = ($urandom_range(0, 5) == 0);
            if (m_phase == 0) epc_i = $urandom;
            step();
            check_model($sformatf("rnd%0d", c));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
